// File: rtl/fifo_axi_lcl_pkg.sv
// Shared types and sizing constants for the FIFO-to-AXI-Stream drain block.
package fifo_axi_lcl_pkg;

    localparam int DW_DEF         = 64;
    localparam int SKID_DEPTH_DEF = 4;

    // Occupancy needs one extra bit so that "full" is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int OCC_W_DEF = $clog2(SKID_DEPTH_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        LAST   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/drain_skid_buf.sv
// Small synchronous FIFO holding fetched words (data plus last-tag) until
// the stream side accepts them.
module drain_skid_buf
    import fifo_axi_lcl_pkg::*;
#(
    parameter int WIDTH = DW_DEF + 1,
    parameter int DEPTH = SKID_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [occ_width(DEPTH)-1:0] occ,
    output logic [WIDTH-1:0]            head
);

    localparam int OW = occ_width(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [OW-1:0]    occ_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push into a full buffer is only accepted when a pop frees a slot.
    assign do_pop_s  = pop & (occ_r != '0);
    assign do_push_s = push & ((occ_r != FULL) | do_pop_s);

    // Storage array; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            occ_r    <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + OW'(1);
                2'b01:   occ_r <= occ_r - OW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign occ  = occ_r;
    assign head = mem_r[rd_ptr_r];

endmodule

// File: rtl/fifo_axi_lcl_drain.sv
// Drains one frame from a 1-cycle-latency FIFO read port into an AXI-Stream
// master. Optional beat counter enabled by macro DRAIN_BEAT_CNT_EN.
module fifo_axi_lcl_drain
    import fifo_axi_lcl_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic          f_ordy,
    input  logic          f_flush,
    input  logic          f_olast,
    input  logic          f_empty,
    input  logic          f_dv,
    input  logic [DW-1:0] f_dout,
    output logic          f_rdrq,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tlast,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   beat_cnt
);

    localparam int OW  = occ_width(SKID_DEPTH);
    localparam int OWX = OW + 1;
    localparam logic [OWX-1:0] DEPTH_X = OWX'(SKID_DEPTH);

    drain_state_e   state_r;
    drain_state_e   state_nx_s;
    logic           inflight_r;
    logic           tag_r;
    logic           err_r;
    logic           done_r;
    logic [OW-1:0]  occ_s;
    logic [DW:0]    head_s;
    logic [OWX-1:0] outstanding_s;
    logic           rdrq_s;
    logic           pop_s;
    logic           last_pop_s;
    logic           err_evt_s;

    // Requests are throttled so fetched-but-unaccepted words always fit the buffer.
    assign outstanding_s = {1'b0, occ_s} + {{OW{1'b0}}, inflight_r};
    assign rdrq_s = en & f_ordy & ~f_empty & ~clr & ~tag_r
                  & (state_r == STREAM) & (outstanding_s < DEPTH_X);

    assign m_tvalid   = (occ_s != '0);
    assign pop_s      = m_tvalid & m_tready;
    assign last_pop_s = pop_s & head_s[DW] & (state_r == LAST);
    assign err_evt_s  = (f_dv & ~inflight_r) | (inflight_r & ~f_dv)
                      | (rdrq_s & f_olast & ~f_flush);

    drain_skid_buf #(
        .WIDTH (DW + 1),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (f_dv & ~clr),
        .push_data ({tag_r, f_dout}),
        .pop       (pop_s),
        .occ       (occ_s),
        .head      (head_s)
    );

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (en & f_ordy) state_nx_s = STREAM;
                else             state_nx_s = IDLE;
            end
            STREAM: begin
                if (rdrq_s & f_olast) state_nx_s = LAST;
                else                  state_nx_s = STREAM;
            end
            LAST: begin
                if (last_pop_s) state_nx_s = IDLE;
                else            state_nx_s = LAST;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_r <= IDLE;
        else if (clr) state_r <= IDLE;
        else          state_r <= state_nx_s;
    end

    // Read tracking: one outstanding read, and the last-word tag for its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
            tag_r      <= 1'b0;
        end else if (clr) begin
            inflight_r <= 1'b0;
            tag_r      <= 1'b0;
        end else begin
            inflight_r <= rdrq_s;
            tag_r      <= rdrq_s & f_olast;
        end
    end

    // Sticky protocol error and frame-end pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (clr) begin
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            err_r  <= err_r | err_evt_s;
            done_r <= last_pop_s;
        end
    end

`ifdef DRAIN_BEAT_CNT_EN
    logic [15:0] beat_cnt_r;

    // Accepted-beat counter, restarted when a new frame begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 16'h0000;
        end else if (clr) begin
            beat_cnt_r <= 16'h0000;
        end else if ((state_r == IDLE) && (state_nx_s == STREAM)) begin
            beat_cnt_r <= 16'h0000;
        end else if (pop_s && (beat_cnt_r != 16'hFFFF)) begin
            beat_cnt_r <= beat_cnt_r + 16'h0001;
        end
    end

    assign beat_cnt = beat_cnt_r;
`else
    assign beat_cnt = 16'h0000;
`endif

    assign f_rdrq  = rdrq_s;
    assign m_tdata = head_s[DW-1:0];
    assign m_tlast = head_s[DW];
    assign busy    = (state_r != IDLE);
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: doc/fifo_axi_lcl_drain.md
FIFO_AXI_LCL_DRAIN -- requirements
Module: fifo_axi_lcl_drain

Interface
REQ-001 SHALL have a single clock, clk, and reset rst_n, which is asynchronous and active-low; all ports below are synchronous to clk.
REQ-002 SHALL define parameter DW, default 64, as the data width of the FIFO read port and the stream output.
REQ-003 SHALL define parameter SKID_DEPTH, default 4, as the number of output buffer entries; it is a power of two and at least 2.
REQ-004 Ports:
- clk, in, 1: clock.
- rst_n, in, 1: async active-low reset.
- clr, in, 1: synchronous abort/clear.
- en, in, 1: drain enable.
- f_ordy, in, 1: FIFO output ready.
- f_flush, in, 1: FIFO flush phase active.
- f_olast, in, 1: combinational last-word flag for the current f_rdrq.
- f_empty, in, 1: FIFO empty.
- f_dv, in, 1: FIFO read data valid.
- f_dout, in, DW: FIFO read data.
- f_rdrq, out, 1: FIFO read request.
- m_tvalid, out, 1: stream valid.
- m_tready, in, 1: stream ready.
- m_tdata, out, DW: stream data.
- m_tlast, out, 1: last beat of the frame.
- busy, out, 1: frame in progress.
- done, out, 1: one-cycle pulse at frame end.
- err, out, 1: sticky protocol error.
- beat_cnt, out, 16: accepted beats in the current frame.

Function
REQ-005 SHALL assert f_rdrq = en & f_ordy & ~f_empty & (state==STREAM) & (occ + inflight < SKID_DEPTH); f_rdrq is combinational from registered state/counters plus these inputs.
REQ-006 SHALL assume FIFO read latency of exactly 1 cycle: inflight is a 1-bit register set by f_rdrq and cleared the next cycle.
REQ-007 SHALL capture f_dout into the skid buffer whenever f_dv=1, together with a tag bit equal to the registered value of (f_rdrq & f_olast) from the previous cycle.
REQ-008 SHALL present the skid head as m_tdata and its tag as m_tlast; m_tvalid=1 iff occ>0; head pops on m_tvalid & m_tready.
REQ-009 SHALL allow a simultaneous push and pop in one cycle with occ unchanged; the skid buffer SHALL never overflow under REQ-005.
REQ-010 SHALL hold m_tdata/m_tlast stable while m_tvalid & ~m_tready (AXI-Stream rule).
REQ-011 State machine IDLE -> STREAM when en & f_ordy; STREAM -> LAST when f_rdrq & f_olast; LAST -> IDLE when the tagged beat is popped; done=1 for the cycle after the LAST->IDLE transition.
REQ-012 SHALL never assert f_rdrq in the LAST state, nor in the cycle after f_olast, so the FIFO's "no rdrq after olast" rule holds.
REQ-013 busy=1 in STREAM and LAST; busy=0 in IDLE.
REQ-014 SHALL set err (sticky until clr/reset) on f_dv without inflight, on inflight without f_dv, or on f_olast seen while f_flush=0.
REQ-015 Deasserting en mid-frame SHALL stop new requests only; in-flight and buffered beats still drain.
REQ-016 clr SHALL, in the same edge, empty the skid buffer, clear inflight/err/beat_cnt, force IDLE, drop m_tvalid, and suppress f_rdrq during its cycle.

Reset
REQ-017 On rst_n=0: f_rdrq=0, m_tvalid=0, m_tdata=0, m_tlast=0, busy=0, done=0, err=0, beat_cnt=0, state=IDLE, occ=0, inflight=0.
REQ-018 Reset asserted mid-frame SHALL discard all buffered data; the frame is not resumed after reset release.

Configuration
REQ-019 Macro DRAIN_BEAT_CNT_EN:
- Defined: beat_cnt increments on each accepted beat, saturates at 16'hFFFF, clears on the IDLE->STREAM transition, and holds its value after done.
- Undefined: beat_cnt is tied to 0 and no counter logic is synthesized.

Structure
REQ-020 Package fifo_axi_lcl_pkg SHALL hold the state enum (IDLE, STREAM, LAST), the DW/SKID_DEPTH defaults, and the occupancy-width constant.
REQ-021 Sub-module drain_skid_buf SHALL implement the SKID_DEPTH x (DW+1) synchronous FIFO with push, pop, occ, and head outputs.

Verification
REQ-022 Single frame of 5 words, m_tready=1: 5 beats 0x1..0x5, m_tlast only on 0x5, done one cycle later, beat_cnt=5.
REQ-023 m_tready=0 for 10 cycles mid-frame: f_rdrq stops once occ+inflight=4, no data is lost or reordered, and err=0.
REQ-024 f_ordy toggling every 3 cycles: requests only occur while f_ordy=1, and all 20 words arrive in order.
REQ-025 clr pulse with occ=3: next cycle m_tvalid=0, state IDLE, beat_cnt=0, and a subsequent frame of 2 words streams normally.
REQ-026 Injected f_dv without a prior f_rdrq: err=1 and it stays 1 until clr.
